// File: rtl/uni2bin_dec.sv
`default_nettype none
// ============================================================================
//  Module      : uni2bin_dec
//  Description : Unary-to-binary decoder. Counts the 1s of a unary bitstream
//                over a window of 2**BITWIDTH cycles and returns the
//                saturated count through a valid/ready output register.
//  Revision    : 1.0  initial release
// ============================================================================
module uni2bin_dec #(
    parameter int BITWIDTH   = 8,
    parameter bit CONTINUOUS = 1'b0
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iStart,
    input  logic                iBit,
    input  logic                iClr,
    output logic [BITWIDTH-1:0] oData,
    output logic                oValid,
    input  logic                iReady,
    output logic                oBusy,
    output logic                oOvf
);

    // FSM encoding
    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;

    // Index of the final cycle of a window (WIN-1 is all ones)
    localparam logic [BITWIDTH-1:0] c_LAST_CYCLE = '1;

    logic [0:0]          r_state;
    logic [BITWIDTH-1:0] r_winCnt;
    logic [BITWIDTH:0]   r_acc;
    logic [BITWIDTH-1:0] r_data;
    logic                r_valid;
    logic                r_ovf;

    logic [BITWIDTH:0]   w_accNext;
    logic                w_last;
    logic [BITWIDTH-1:0] w_result;
    logic                w_accept;

    // The accumulator is held at 0 in IDLE, so the starting cycle's bit
    // lands correctly through the same adder used in RUN.
    assign w_accNext = r_acc + (BITWIDTH+1)'(iBit);

    // Cycle 0 happens in IDLE, so the closing cycle is always seen in RUN.
    assign w_last    = (r_state == c_RUN) && (r_winCnt == c_LAST_CYCLE);

    // Only an all-ones window reaches 2**BITWIDTH, which sets the top bit.
    assign w_result  = w_accNext[BITWIDTH] ? '1 : w_accNext[BITWIDTH-1:0];

    assign w_accept  = r_valid && iReady;

    // Window sequencing: state, cycle counter and running count
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state  <= c_IDLE;
            r_winCnt <= '0;
            r_acc    <= '0;
        end else if (iClr) begin
            r_state  <= c_IDLE;
            r_winCnt <= '0;
            r_acc    <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (iStart) begin
                        r_state  <= c_RUN;
                        r_winCnt <= BITWIDTH'(1);
                        r_acc    <= w_accNext;
                    end
                end
                c_RUN: begin
                    if (w_last) begin
                        r_state  <= CONTINUOUS ? c_RUN : c_IDLE;
                        r_winCnt <= '0;
                        r_acc    <= '0;
                    end else begin
                        r_winCnt <= r_winCnt + BITWIDTH'(1);
                        r_acc    <= w_accNext;
                    end
                end
                default: begin
                    r_state  <= c_IDLE;
                    r_winCnt <= '0;
                    r_acc    <= '0;
                end
            endcase
        end
    end

    // Output register: load on window end unless an unconsumed result blocks it
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (iClr) begin
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_last) begin
            if (!r_valid || iReady) begin
                r_data  <= w_result;
                r_valid <= 1'b1;
            end else begin
                r_ovf   <= 1'b1;
            end
        end else if (w_accept) begin
            r_valid <= 1'b0;
        end
    end

    assign oData  = r_data;
    assign oValid = r_valid;
    assign oOvf   = r_ovf;
    assign oBusy  = (r_state == c_RUN);

endmodule
`default_nettype wire

// File: tb/tb_uni2bin_dec.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uni2bin_dec
//  Description : Bench for uni2bin_dec. Two instances (single-shot and
//                continuous) share stimulus; a window-level model pushes
//                expected results into per-instance queues and a monitor
//                pops and compares on every accepted output.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uni2bin_dec;

    localparam int BW  = 8;
    localparam int WIN = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, bitIn, clr, ready;
    logic [BW-1:0] data0, data1;
    logic valid0, valid1, busy0, busy1, ovf0, ovf1;

    uni2bin_dec #(.BITWIDTH(BW), .CONTINUOUS(1'b0)) u_dut0 (
        .iClk(clk), .iRst(rst), .iStart(start), .iBit(bitIn), .iClr(clr),
        .oData(data0), .oValid(valid0), .iReady(ready), .oBusy(busy0), .oOvf(ovf0)
    );

    uni2bin_dec #(.BITWIDTH(BW), .CONTINUOUS(1'b1)) u_dut1 (
        .iClk(clk), .iRst(rst), .iStart(start), .iBit(bitIn), .iClr(clr),
        .oData(data1), .oValid(valid1), .iReady(ready), .oBusy(busy1), .oOvf(ovf1)
    );

    logic [BW-1:0] dData [2];
    logic          dValid[2];
    logic          dBusy [2];
    logic          dOvf  [2];
    assign dData[0] = data0;  assign dData[1] = data1;
    assign dValid[0] = valid0; assign dValid[1] = valid1;
    assign dBusy[0] = busy0;  assign dBusy[1] = busy1;
    assign dOvf[0] = ovf0;    assign dOvf[1] = ovf1;

    int checks   = 0;
    int failures = 0;
    bit monOn    = 1'b0;

    // Reference model: window-level bookkeeping per instance
    int mSum[2], mIdx[2];
    bit mRun[2], mValid[2], mOvf[2];
    int q0[$], q1[$];
    int lastData[2];
    int pops[2];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void qPush(int k, int v);
        if (k == 0) q0.push_back(v); else q1.push_back(v);
    endfunction

    function automatic void qClear(int k);
        if (k == 0) q0.delete(); else q1.delete();
    endfunction

    function automatic void modelStep(int k, bit cont, bit r, bit s, bit b, bit c, bit rdy);
        bit done;
        int res;
        done = 1'b0;
        res  = 0;
        if (r || c) begin
            mRun[k] = 0; mSum[k] = 0; mIdx[k] = 0;
            mValid[k] = 0; mOvf[k] = 0;
            qClear(k);
        end else begin
            if (mRun[k] || s) begin
                mRun[k] = 1;
                mSum[k] += int'(b);
                mIdx[k]++;
                if (mIdx[k] == WIN) begin
                    done = 1'b1;
                    res  = (mSum[k] > WIN - 1) ? WIN - 1 : mSum[k];
                    mSum[k] = 0;
                    mIdx[k] = 0;
                    mRun[k] = cont;
                end
            end
            if (done) begin
                if (!mValid[k] || rdy) begin
                    qPush(k, res);
                    mValid[k] = 1;
                end else begin
                    mOvf[k] = 1;
                end
            end else if (mValid[k] && rdy) begin
                mValid[k] = 0;
            end
        end
    endfunction

    // One clock: inputs already driven; model advances with the edge
    task automatic cyc();
        bit r, s, b, c, y;
        r = rst; s = start; b = bitIn; c = clr; y = ready;
        @(posedge clk);
        modelStep(0, 1'b0, r, s, b, c, y);
        modelStep(1, 1'b1, r, s, b, c, y);
        #1;
    endtask

    task automatic idle(int n);
        start = 0; bitIn = 0;
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic runWin(int ones);
        for (int i = 0; i < WIN; i++) begin
            start = (i == 0);
            bitIn = (i < ones);
            cyc();
        end
        start = 0; bitIn = 0;
    endtask

    task automatic clrPulse();
        clr = 1; cyc(); clr = 0;
    endtask

    // Monitor: status against model every cycle, data popped on acceptance
    always @(negedge clk) begin
        if (monOn) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("valid%0d", k), 32'(dValid[k]), 32'(mValid[k]));
                chk($sformatf("busy%0d", k),  32'(dBusy[k]),  32'(mRun[k]));
                chk($sformatf("ovf%0d", k),   32'(dOvf[k]),   32'(mOvf[k]));
                if (dValid[k] && ready && !rst && !clr) begin
                    int exp;
                    bit empty;
                    empty = (k == 0) ? (q0.size() == 0) : (q1.size() == 0);
                    if (empty) begin
                        checks++;
                        failures++;
                        $display("FAIL pop%0d: got data %0d expected no result", k, dData[k]);
                    end else begin
                        exp = (k == 0) ? q0.pop_front() : q1.pop_front();
                        chk($sformatf("data%0d", k), 32'(dData[k]), 32'(exp));
                    end
                    lastData[k] = int'(dData[k]);
                    pops[k]++;
                end
            end
        end
    end

    initial begin
        int ones, p0, p1, dens;
        rst = 1; start = 0; bitIn = 0; clr = 0; ready = 1;
        for (int k = 0; k < 2; k++) begin
            lastData[k] = -1; pops[k] = 0;
        end
        cyc(); cyc();
        rst = 0;
        chk("rst_data0", 32'(data0), 0);
        chk("rst_data1", 32'(data1), 0);
        chk("rst_valid", 32'({valid0, valid1}), 0);
        chk("rst_busy",  32'({busy0, busy1}), 0);
        chk("rst_ovf",   32'({ovf0, ovf1}), 0);
        monOn = 1;

        // Saturating all-ones window
        ready = 1;
        p0 = pops[0];
        runWin(WIN);
        idle(2);
        chk("t1_data", 32'(lastData[0]), 255);
        chk("t1_pops", 32'(pops[0] - p0), 1);
        chk("t1_busy", 32'(busy0), 0);

        // Partial count then all-zero window
        clrPulse();
        runWin(157);
        idle(2);
        chk("t2_data157", 32'(lastData[0]), 157);
        runWin(0);
        idle(2);
        chk("t2_data0", 32'(lastData[0]), 0);

        // Back-pressure: second result dropped and flagged
        clrPulse();
        ready = 0;
        runWin(64);
        runWin(32);
        idle(1);
        chk("t3_data", 32'(data1), 64);
        chk("t3_valid", 32'(valid1), 1);
        chk("t3_ovf", 32'(ovf1), 1);
        ready = 1;
        cyc();
        chk("t3_valid_drop", 32'(valid1), 0);
        chk("t3_ovf_sticky", 32'(ovf1), 1);
        clrPulse();
        chk("t3_ovf_clr", 32'(ovf1), 0);
        chk("t3_data_kept", 32'(data1), 64);

        // Continuous back-to-back windows of alternating bits
        ready = 1;
        p1 = pops[1];
        for (int i = 0; i < 3 * WIN; i++) begin
            start = (i == 0);
            bitIn = (i % 2 == 0);
            cyc();
        end
        start = 0; bitIn = 0;
        cyc();
        chk("t4_pops", 32'(pops[1] - p1), 3);
        chk("t4_data", 32'(lastData[1]), 128);
        chk("t4_ovf", 32'(ovf1), 0);

        // Abort at window cycle 100, then a short restart
        clrPulse();
        for (int i = 0; i < 100; i++) begin
            start = (i == 0); bitIn = 1; cyc();
        end
        clr = 1; start = 1; cyc(); clr = 0; start = 0;
        chk("t5_busy", 32'({busy0, busy1}), 0);
        chk("t5_valid", 32'({valid0, valid1}), 0);
        chk("t5_ovf", 32'({ovf0, ovf1}), 0);
        runWin(10);
        idle(2);
        chk("t5_data0", 32'(lastData[0]), 10);
        chk("t5_data1", 32'(lastData[1]), 10);

        // Reset mid-window, then a random window with no residue
        for (int i = 0; i < 50; i++) begin
            start = (i == 0); bitIn = 1; cyc();
        end
        rst = 1; cyc(); rst = 0;
        chk("t6_data", 32'({data0, data1}), 0);
        chk("t6_flags", 32'({valid0, valid1, busy0, busy1, ovf0, ovf1}), 0);
        ones = 0;
        for (int i = 0; i < WIN; i++) begin
            start = (i == 0);
            bitIn = 1'($urandom_range(0, 1));
            ones += int'(bitIn);
            cyc();
        end
        idle(2);
        chk("t6_count", 32'(lastData[0]), 32'(ones));

        // Randomized traffic
        dens = 50;
        for (int n = 0; n < 3000; n++) begin
            if (n % WIN == 0) dens = int'($urandom_range(0, 100));
            start = ($urandom_range(0, 15) == 0);
            bitIn = ($urandom_range(0, 99) < dens);
            ready = ($urandom_range(0, 3) != 0);
            clr   = ($urandom_range(0, 499) == 0);
            rst   = ($urandom_range(0, 1499) == 0);
            cyc();
        end
        rst = 0; clr = 0; ready = 1;
        idle(3);

        monOn = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
